// File: rtl/sel_pkg.sv
// Shared definitions for the decoder select generator: index sizing,
// debouncer state encoding and counter-width helper.
package sel_pkg;

    localparam int IDX_W   = 3;
    localparam int NUM_IDX = 8;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } deb_state_t;

    // Counters must be at least one bit wide, even for tiny parameters.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability-counting debounce
// FSM and a single-cycle press pulse on each accepted press.
//
//   state    | meaning
//   RELEASED | debounced level low; counting cycles of synchronized high
//   PRESSED  | debounced level high; counting cycles of synchronized low
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    import sel_pkg::*;

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             level;
    deb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pulse_nxt;

    assign level = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b00;
            state <= RELEASED;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
        end
    end

    // The counter only runs while the synchronized level disagrees with the state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        pulse_nxt = 1'b0;
        if (level != (state == PRESSED)) begin
            if (cnt == CNT_LAST) begin
                state_nxt = (state == PRESSED) ? RELEASED : PRESSED;
                pulse_nxt = (state == RELEASED);
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec_sel_gen.sv
// Select/enable generator for a 3-to-8 decoder: debounced next/prev/enable
// buttons plus an optional auto-scan that steps the index periodically.
module dec_sel_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_PERIOD     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_en,
    input  logic       sw_auto,
    output logic [2:0] x,
    output logic       en
);
    import sel_pkg::*;

    localparam int               SCAN_W    = cnt_width(SCAN_PERIOD);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

    logic              p_next, p_prev, p_en;
    logic [1:0]        auto_sync;
    logic [SCAN_W-1:0] scan, scan_nxt;
    logic [2:0]        x_nxt;
    logic              en_nxt;
    logic              manual;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clk(clk), .rst(rst), .raw(btn_next), .pulse(p_next)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
        .clk(clk), .rst(rst), .raw(btn_prev), .pulse(p_prev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_en (
        .clk(clk), .rst(rst), .raw(btn_en), .pulse(p_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            auto_sync <= 2'b00;
            scan      <= '0;
            x         <= '0;
            en        <= 1'b0;
        end else begin
            auto_sync <= {auto_sync[0], sw_auto};
            scan      <= scan_nxt;
            x         <= x_nxt;
            en        <= en_nxt;
        end
    end

    assign manual = p_next | p_prev;

    // Manual steps take priority over a scan tick and restart the scan period.
    always_comb begin
        x_nxt    = x;
        en_nxt   = en ^ p_en;
        scan_nxt = '0;
        if (p_next && !p_prev) begin
            x_nxt = x + 3'd1;
        end else if (p_prev && !p_next) begin
            x_nxt = x - 3'd1;
        end
        if (auto_sync[1] && en && !manual) begin
            if (scan == SCAN_LAST) begin
                x_nxt = x + 3'd1;
            end else begin
                scan_nxt = scan + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dec_sel_gen.sv
// Randomized and directed bench for dec_sel_gen against a cycle-level
// behavioural model built from delay lines and stability run lengths.
module tb_dec_sel_gen;

    localparam int DEB  = 4;
    localparam int SCAN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       btn_en = 1'b0;
    logic       sw_auto = 1'b0;
    logic [2:0] x;
    logic       en;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit m_d0[4];
    bit m_d1[4];
    bit m_deb[3];
    int m_run[3];
    bit m_pend[3];
    int m_x;
    bit m_en;
    int m_since;

    dec_sel_gen #(.DEBOUNCE_CYCLES(DEB), .SCAN_PERIOD(SCAN)) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
        .btn_en(btn_en), .sw_auto(sw_auto), .x(x), .en(en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit raw[4];
        bit lvl[4];
        bit manual;
        raw = '{btn_next, btn_prev, btn_en, sw_auto};
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_d0[i] = 0;
                m_d1[i] = 0;
            end
            for (int i = 0; i < 3; i++) begin
                m_deb[i] = 0;
                m_run[i] = 0;
                m_pend[i] = 0;
            end
            m_x = 0;
            m_en = 0;
            m_since = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            lvl[i]  = m_d1[i];
            m_d1[i] = m_d0[i];
            m_d0[i] = raw[i];
        end
        manual = m_pend[0] | m_pend[1];
        if (m_pend[0] && !m_pend[1]) m_x = (m_x + 1) % 8;
        else if (m_pend[1] && !m_pend[0]) m_x = (m_x + 7) % 8;
        if (lvl[3] && m_en && !manual) begin
            m_since++;
            if (m_since == SCAN) begin
                m_x = (m_x + 1) % 8;
                m_since = 0;
            end
        end else begin
            m_since = 0;
        end
        if (m_pend[2]) m_en = !m_en;
        // a level is accepted after DEB consecutive disagreeing samples
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 0;
            if (lvl[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = lvl[i];
                    m_run[i] = 0;
                    m_pend[i] = lvl[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("x", int'(x), m_x);
        chk("en", int'(en), int'(m_en));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_next = 0; btn_prev = 0; btn_en = 0; sw_auto = 0;
        cycle();
        cycle();
        chk("rst_x", int'(x), 0);
        chk("rst_en", int'(en), 0);
        rst = 1'b0;
    endtask

    task automatic press(input bit n, input bit p, input bit e, input int hold);
        btn_next = n; btn_prev = p; btn_en = e;
        repeat (hold) cycle();
        btn_next = 0; btn_prev = 0; btn_en = 0;
        repeat (8) cycle();
    endtask

    initial begin
        int guard;
        // clean press from reset lands at cycle 7
        do_reset();
        btn_next = 1;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            chk("r030_x", int'(x), (c >= 7) ? 1 : 0);
        end
        btn_next = 0;
        repeat (10) cycle();

        // bouncing input never qualifies
        do_reset();
        for (int c = 0; c < 30; c++) begin
            btn_next = ((c / 2) % 2 == 0);
            cycle();
            chk("r031_x", int'(x), 0);
        end
        btn_next = 0;
        repeat (10) cycle();
        chk("r031_end", int'(x), 0);

        // wrap both ways and cancel
        do_reset();
        press(0, 1, 0, 8);
        chk("r032_wrap_dn", int'(x), 7);
        press(1, 0, 0, 8);
        chk("r032_wrap_up", int'(x), 0);
        press(1, 1, 0, 8);
        chk("r032_cancel", int'(x), 0);

        // auto scan, freeze, manual press at assorted scan phases
        do_reset();
        sw_auto = 1;
        press(0, 0, 1, 8);
        chk("r033_en", int'(en), 1);
        repeat (30) cycle();
        sw_auto = 0;
        repeat (12) cycle();
        sw_auto = 1;
        for (int off = 0; off < 6; off++) begin
            repeat (off) cycle();
            press(1, 0, 0, 6);
        end

        // reset mid-scan with a button held across it
        do_reset();
        sw_auto = 1;
        press(0, 0, 1, 6);
        guard = 0;
        while (m_x != 5 && guard < 100) begin
            cycle();
            guard++;
        end
        chk("r035_reach5", m_x, 5);
        btn_next = 1;
        cycle();
        rst = 1;
        cycle();
        chk("r035_x", int'(x), 0);
        chk("r035_en", int'(en), 0);
        rst = 0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            chk("r035_held", int'(x), (c >= 7) ? 1 : 0);
        end
        btn_next = 0;
        repeat (8) cycle();

        // random soak
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 7) == 0) btn_prev = ~btn_prev;
            if ($urandom_range(0, 11) == 0) btn_en = ~btn_en;
            if ($urandom_range(0, 40) == 0) sw_auto = ~sw_auto;
            rst = ($urandom_range(0, 400) == 0);
            cycle();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
